// File: rtl/bcd_stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its surroundings:
// raw buttons and counter value in, counter control and display/status out.
`timescale 1ns/1ps
interface bcd_stopwatch_ctrl_if #(
    parameter int DW = 16
);
    logic          btn_ss;
    logic          btn_lr;
    logic [DW-1:0] count_in;
    logic          cnt_tick;
    logic          cnt_clr;
    logic [DW-1:0] disp_bcd;
    logic          running;
    logic          lap_hold;
    logic          overflow;

    modport master (
        input  btn_ss, btn_lr, count_in,
        output cnt_tick, cnt_clr, disp_bcd, running, lap_hold, overflow
    );

    modport slave (
        output btn_ss, btn_lr, count_in,
        input  cnt_tick, cnt_clr, disp_bcd, running, lap_hold, overflow
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and lap/reset buttons drive a
// RUN/PAUSE/LAP/DONE FSM that ticks and clears an external 4-digit BCD counter.
`timescale 1ns/1ps
module bcd_stopwatch_ctrl #(
    parameter int DIV = 50000,
    parameter int DEB = 16,
    parameter int DW  = 16
) (
    input  logic                 mclk,
    input  logic                 reset,
    bcd_stopwatch_ctrl_if.master bus
);
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int            CW   = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [DW-1:0] FULL = DW'(16'h9999);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_LAP   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic running;
        logic lap_hold;
        logic overflow;
    } status_t;

    function automatic status_t decode(input state_t s);
        status_t d;
        d.running  = (s == S_RUN) || (s == S_LAP);
        d.lap_hold = (s == S_LAP);
        d.overflow = (s == S_DONE);
        return d;
    endfunction

    // Button path: index 0 is start/stop, index 1 is lap/reset.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [1:0]    press;
    logic [CW-1:0] deb_cnt [2];

    assign raw = {bus.btn_lr, bus.btn_ss};

    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int b = 0; b < 2; b++) deb_cnt[b] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int b = 0; b < 2; b++) begin
                press[b] <= 1'b0;
                if (sync2[b] == level[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == CW'(DEB - 1)) begin
                    // DEB-th consecutive differing sample: accept, pulse only on a press
                    deb_cnt[b] <= '0;
                    level[b]   <= sync2[b];
                    press[b]   <= sync2[b];
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    state_t        state;
    status_t       status;
    logic [PW-1:0] pre;
    logic [DW-1:0] lap_reg;
    logic [DW-1:0] disp_q;
    logic          tick_q;
    logic          clr_q;
    logic          ss_ev;
    logic          lr_ev;
    logic          active;
    logic          term;
    logic          full;

    // A simultaneous start/stop press takes priority and swallows lap/reset.
    assign ss_ev  = press[0];
    assign lr_ev  = press[1] & ~press[0];
    assign active = (state == S_RUN) || (state == S_LAP);
    assign term   = active && (pre == PW'(DIV - 1));
    assign full   = (bus.count_in == FULL);

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            status  <= '0;
            pre     <= '0;
            lap_reg <= '0;
            disp_q  <= '0;
            tick_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            // The tick follows T even when a press changes state in the same cycle.
            tick_q <= term & ~full;
            clr_q  <= 1'b0;
            disp_q <= (state == S_LAP) ? lap_reg : bus.count_in;
            if (active) pre <= term ? '0 : pre + 1'b1;

            case (state)
                S_IDLE: begin
                    if (ss_ev) begin
                        state  <= S_RUN;
                        status <= decode(S_RUN);
                    end else if (lr_ev) begin
                        clr_q <= 1'b1;
                        pre   <= '0;
                    end
                end
                S_RUN: begin
                    if (ss_ev) begin
                        state  <= S_PAUSE;
                        status <= decode(S_PAUSE);
                    end else if (lr_ev) begin
                        state   <= S_LAP;
                        status  <= decode(S_LAP);
                        lap_reg <= bus.count_in;
                    end else if (term && full) begin
                        state  <= S_DONE;
                        status <= decode(S_DONE);
                    end
                end
                S_LAP: begin
                    if (ss_ev) begin
                        state  <= S_PAUSE;
                        status <= decode(S_PAUSE);
                    end else if (lr_ev) begin
                        state  <= S_RUN;
                        status <= decode(S_RUN);
                    end else if (term && full) begin
                        state  <= S_DONE;
                        status <= decode(S_DONE);
                    end
                end
                S_PAUSE: begin
                    if (ss_ev) begin
                        state  <= S_RUN;
                        status <= decode(S_RUN);
                    end else if (lr_ev) begin
                        state  <= S_IDLE;
                        status <= decode(S_IDLE);
                        clr_q  <= 1'b1;
                        pre    <= '0;
                    end
                end
                S_DONE: begin
                    if (lr_ev) begin
                        state  <= S_IDLE;
                        status <= decode(S_IDLE);
                        clr_q  <= 1'b1;
                        pre    <= '0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    status <= decode(S_IDLE);
                end
            endcase
        end
    end

    assign bus.cnt_tick = tick_q;
    assign bus.cnt_clr  = clr_q;
    assign bus.disp_bcd = disp_q;
    assign bus.running  = status.running;
    assign bus.lap_hold = status.lap_hold;
    assign bus.overflow = status.overflow;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl: directed scenarios followed by
// random button/counter stimulus, all compared against a behavioural model.
`timescale 1ns/1ps
module tb_bcd_stopwatch_ctrl;
    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int DW  = 16;

    logic mclk;
    logic reset;

    bcd_stopwatch_ctrl_if #(.DW(DW)) bus ();

    bcd_stopwatch_ctrl #(.DIV(DIV), .DEB(DEB), .DW(DW)) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: modes named after the stopwatch's behaviour,
    // buttons modelled as a 2-sample delay line plus a DEB-long history window.
    typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSE, M_DONE} mode_t;
    mode_t       m_mode;
    int          m_pre;
    logic [15:0] m_lap;
    bit          m_acc  [2];
    bit          m_pend [2];
    bit          sync_q [2][$];
    bit          hist_q [2][$];

    logic        e_tick, e_clr, e_run, e_lap, e_ovf;
    logic [15:0] e_disp;

    int n_tick_seen;
    int n_clr_seen;
    bit lap_seen;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pre  = 0;
        m_lap  = '0;
        e_tick = 0; e_clr = 0; e_run = 0; e_lap = 0; e_ovf = 0; e_disp = '0;
        for (int b = 0; b < 2; b++) begin
            m_acc[b]  = 0;
            m_pend[b] = 0;
            sync_q[b].delete();
            hist_q[b].delete();
            sync_q[b].push_back(1'b0);
            sync_q[b].push_back(1'b0);
        end
    endtask

    task automatic model_step();
        bit    ss, lr, t, full, s, all_eq;
        bit    raw [2];
        mode_t nm;
        ss   = m_pend[0];
        lr   = m_pend[1] && !m_pend[0];
        t    = (m_mode == M_RUN || m_mode == M_LAP) && (m_pre == DIV - 1);
        full = (bus.count_in == 16'h9999);
        e_tick = t && !full;
        e_clr  = 0;
        e_disp = (m_mode == M_LAP) ? m_lap : bus.count_in;
        if (m_mode == M_RUN || m_mode == M_LAP) m_pre = (m_pre + 1) % DIV;
        nm = m_mode;
        case (m_mode)
            M_IDLE:  if (ss) nm = M_RUN;
                     else if (lr) begin e_clr = 1; m_pre = 0; end
            M_RUN:   if (ss) nm = M_PAUSE;
                     else if (lr) begin nm = M_LAP; m_lap = bus.count_in; end
                     else if (t && full) nm = M_DONE;
            M_LAP:   if (ss) nm = M_PAUSE;
                     else if (lr) nm = M_RUN;
                     else if (t && full) nm = M_DONE;
            M_PAUSE: if (ss) nm = M_RUN;
                     else if (lr) begin nm = M_IDLE; e_clr = 1; m_pre = 0; end
            M_DONE:  if (lr) begin nm = M_IDLE; e_clr = 1; m_pre = 0; end
            default: nm = M_IDLE;
        endcase
        m_mode = nm;
        e_run  = (nm == M_RUN) || (nm == M_LAP);
        e_lap  = (nm == M_LAP);
        e_ovf  = (nm == M_DONE);

        raw[0] = bus.btn_ss;
        raw[1] = bus.btn_lr;
        for (int b = 0; b < 2; b++) begin
            s = sync_q[b].pop_front();
            sync_q[b].push_back(raw[b]);
            hist_q[b].push_back(s);
            if (hist_q[b].size() > DEB) void'(hist_q[b].pop_front());
            m_pend[b] = 0;
            if (hist_q[b].size() == DEB) begin
                all_eq = 1;
                for (int i = 0; i < hist_q[b].size(); i++)
                    if (hist_q[b][i] != s) all_eq = 0;
                if (all_eq && s != m_acc[b]) begin
                    m_acc[b]  = s;
                    m_pend[b] = s;
                end
            end
        end
    endtask

    task automatic compare();
        check("tick",     bus.cnt_tick, e_tick);
        check("clr",      bus.cnt_clr,  e_clr);
        check("disp",     bus.disp_bcd, e_disp);
        check("running",  bus.running,  e_run);
        check("lap_hold", bus.lap_hold, e_lap);
        check("overflow", bus.overflow, e_ovf);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge mclk);
            model_step();
            #1;
            compare();
            if (bus.cnt_tick === 1'b1) n_tick_seen++;
            if (bus.cnt_clr === 1'b1)  n_clr_seen++;
            if (bus.lap_hold === 1'b1) lap_seen = 1;
        end
    endtask

    task automatic press(input bit ss, input bit lr);
        bus.btn_ss = ss;
        bus.btn_lr = lr;
        cyc(10);
        bus.btn_ss = 1'b0;
        bus.btn_lr = 1'b0;
        cyc(DEB + 6);
    endtask

    task automatic clear_seen();
        n_tick_seen = 0;
        n_clr_seen  = 0;
        lap_seen    = 0;
    endtask

    initial begin
        int k;
        int hold [2];
        bit lvl;

        reset        = 1'b1;
        bus.btn_ss   = 1'b0;
        bus.btn_lr   = 1'b0;
        bus.count_in = 16'h0000;
        model_reset();
        clear_seen();
        #1;
        check("rst_tick",     bus.cnt_tick, 0);
        check("rst_clr",      bus.cnt_clr,  0);
        check("rst_disp",     bus.disp_bcd, 0);
        check("rst_running",  bus.running,  0);
        check("rst_lap_hold", bus.lap_hold, 0);
        check("rst_overflow", bus.overflow, 0);
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        reset = 1'b0;

        // 1: idle for 50 cycles, nothing may tick
        cyc(50);
        check("idle_ticks", n_tick_seen, 0);

        // 2: short glitch is rejected; a clean press starts the run DEB+3 cycles later
        bus.btn_ss = 1'b1;
        cyc(2);
        bus.btn_ss = 1'b0;
        cyc(12);
        check("glitch_running", bus.running, 0);

        bus.btn_ss = 1'b1;
        k = 0;
        while (bus.running !== 1'b1 && k < 30) begin
            cyc(1);
            k++;
        end
        check("ss_latency", k, DEB + 3);
        cyc(10 - k);
        bus.btn_ss = 1'b0;
        k = 0;
        while (bus.cnt_tick !== 1'b1 && k < 3 * DIV) begin
            cyc(1);
            k++;
        end
        check("tick_found", bus.cnt_tick, 1);
        k = 0;
        do begin
            cyc(1);
            k++;
        end while (bus.cnt_tick !== 1'b1 && k < 3 * DIV);
        check("tick_period", k, DIV);
        cyc(DEB + 6);

        // 3: lap freezes the display while the counter moves, second lap releases it
        bus.count_in = 16'h0042;
        press(1'b0, 1'b1);
        check("lap_enter", bus.lap_hold, 1);
        bus.count_in = 16'h0043;
        cyc(1);
        bus.count_in = 16'h0044;
        cyc(2);
        check("lap_frozen", bus.disp_bcd, 16'h0042);
        press(1'b0, 1'b1);
        bus.count_in = 16'h0051;
        cyc(2);
        check("lap_live", bus.disp_bcd, 16'h0051);
        check("lap_exit", bus.lap_hold, 0);

        // 4: pause stops ticks, resume restarts them, lr in pause clears once
        press(1'b1, 1'b0);
        check("pause_running", bus.running, 0);
        clear_seen();
        cyc(12);
        check("pause_ticks", n_tick_seen, 0);
        press(1'b1, 1'b0);
        check("resume_running", bus.running, 1);
        press(1'b1, 1'b0);
        clear_seen();
        press(1'b0, 1'b1);
        check("pause_clr_count", n_clr_seen, 1);
        check("idle_after_clr", bus.running, 0);

        // 5: counter at 9999 when T fires -> DONE, no tick, ss ignored, lr clears
        bus.count_in = 16'h9999;
        clear_seen();
        press(1'b1, 1'b0);
        k = 0;
        while (bus.overflow !== 1'b1 && k < 20) begin
            cyc(1);
            k++;
        end
        check("done_overflow", bus.overflow, 1);
        check("done_running",  bus.running,  0);
        check("done_no_tick",  n_tick_seen,  0);
        press(1'b1, 1'b0);
        check("done_ss_ignored", bus.overflow, 1);
        clear_seen();
        press(1'b0, 1'b1);
        check("done_clr_count", n_clr_seen, 1);
        check("done_exit",      bus.overflow, 0);

        // 6: simultaneous presses in RUN -> PAUSE without a lap; async reset mid-run
        bus.count_in = 16'h0000;
        press(1'b1, 1'b0);
        clear_seen();
        press(1'b1, 1'b1);
        check("both_no_lap",  lap_seen, 0);
        check("both_paused",  bus.running, 0);
        press(1'b1, 1'b0);
        cyc(3);
        check("pre_reset_running", bus.running, 1);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_running",  bus.running,  0);
        check("async_disp",     bus.disp_bcd, 0);
        check("async_tick",     bus.cnt_tick, 0);
        check("async_lap_hold", bus.lap_hold, 0);
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        reset = 1'b0;

        // Random phase: buttons held for random lengths, random BCD counter values
        hold[0] = 0;
        hold[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    lvl     = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 14);
                    if (b == 0) bus.btn_ss = lvl;
                    else        bus.btn_lr = lvl;
                end else begin
                    hold[b]--;
                end
            end
            if ($urandom_range(0, 9) == 0)
                bus.count_in = 16'h9999;
            else
                bus.count_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
